// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//   Circular in-order reorder buffer for the Tomasulo core. Dispatch allocates
//   the tail entry and hands its tag to the map table. The CDB marks entries
//   complete. The head entry retires in order toward the map table and the
//   architectural register file.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   flush               squash every entry (overrides everything else)
//   dispatch_*          allocation request / ready / assigned tag
//   cdb_*               completion broadcast (tag + value)
//   query_tag1/2        operand lookups, query_ready1/2 + query_value1/2 out
//   commit_*            retiring head entry (valid, has_dest, reg, tag, value)
//   empty               no busy entries
// ---------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_SIZE     = 8,
    parameter int ROB_ADDR_LEN = 3,
    parameter int REG_ADDR_LEN = 5,
    parameter int XLEN         = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    dispatch_valid,
    input  logic                    dispatch_has_dest,
    input  logic [REG_ADDR_LEN-1:0] dispatch_dest_reg,
    output logic                    dispatch_ready,
    output logic [ROB_ADDR_LEN-1:0] dispatch_rob_tag,
    input  logic                    cdb_valid,
    input  logic [ROB_ADDR_LEN-1:0] cdb_rob_tag,
    input  logic [XLEN-1:0]         cdb_value,
    input  logic [ROB_ADDR_LEN-1:0] query_tag1,
    input  logic [ROB_ADDR_LEN-1:0] query_tag2,
    output logic                    query_ready1,
    output logic                    query_ready2,
    output logic [XLEN-1:0]         query_value1,
    output logic [XLEN-1:0]         query_value2,
    output logic                    commit_valid,
    output logic                    commit_has_dest,
    output logic [REG_ADDR_LEN-1:0] commit_reg_addr,
    output logic [ROB_ADDR_LEN-1:0] commit_rob_tag,
    output logic [XLEN-1:0]         commit_value,
    output logic                    empty
);

    localparam logic [ROB_ADDR_LEN:0] FULL_COUNT = (ROB_ADDR_LEN+1)'(ROB_SIZE);

    logic [ROB_SIZE-1:0]     busy_r;
    logic [ROB_SIZE-1:0]     ready_r;
    logic [ROB_SIZE-1:0]     has_dest_r;
    logic [REG_ADDR_LEN-1:0] dest_reg_r [ROB_SIZE];
    logic [XLEN-1:0]         value_r    [ROB_SIZE];
    logic [ROB_ADDR_LEN-1:0] head_r;
    logic [ROB_ADDR_LEN-1:0] tail_r;
    logic [ROB_ADDR_LEN:0]   count_r;

    logic                    accept_s;
    logic                    fwd1_s;
    logic                    fwd2_s;

    // Dispatch handshake: readiness depends only on the registered count, so a
    // head retiring in the same cycle never frees a slot for a full ROB.
    always_comb begin
        dispatch_ready   = (count_r < FULL_COUNT);
        dispatch_rob_tag = tail_r;
        accept_s         = dispatch_valid && dispatch_ready;
        empty            = (count_r == {(ROB_ADDR_LEN+1){1'b0}});
    end

    // Head retirement view; CDB results reach commit only after they are
    // registered (no same-cycle CDB-to-commit path).
    always_comb begin
        commit_valid    = busy_r[head_r] && ready_r[head_r] && !flush;
        commit_has_dest = has_dest_r[head_r];
        commit_reg_addr = dest_reg_r[head_r];
        commit_rob_tag  = head_r;
        commit_value    = value_r[head_r];
    end

    // Operand lookups with CDB forwarding so a consumer renamed in the same
    // cycle as its producer's broadcast sees the value immediately.
    always_comb begin
        fwd1_s = cdb_valid && (cdb_rob_tag == query_tag1) && busy_r[query_tag1];
        fwd2_s = cdb_valid && (cdb_rob_tag == query_tag2) && busy_r[query_tag2];
        query_ready1 = fwd1_s || (busy_r[query_tag1] && ready_r[query_tag1]);
        query_ready2 = fwd2_s || (busy_r[query_tag2] && ready_r[query_tag2]);
        if (fwd1_s) begin
            query_value1 = cdb_value;
        end else begin
            query_value1 = value_r[query_tag1];
        end
        if (fwd2_s) begin
            query_value2 = cdb_value;
        end else begin
            query_value2 = value_r[query_tag2];
        end
    end

    // Entry state, pointers and occupancy. Completion is applied before the
    // commit clear so a late duplicate CDB write cannot resurrect a retiring
    // entry. A dispatch never targets a busy slot, so it cannot collide with
    // a CDB write or the retiring head.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r     <= '0;
            ready_r    <= '0;
            has_dest_r <= '0;
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                dest_reg_r[i] <= '0;
                value_r[i]    <= '0;
            end
        end else if (flush) begin
            busy_r  <= '0;
            ready_r <= '0;
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (cdb_valid && busy_r[cdb_rob_tag]) begin
                ready_r[cdb_rob_tag] <= 1'b1;
                value_r[cdb_rob_tag] <= cdb_value;
            end
            if (commit_valid) begin
                busy_r[head_r]  <= 1'b0;
                ready_r[head_r] <= 1'b0;
                head_r          <= head_r + ROB_ADDR_LEN'(1);
            end
            if (accept_s) begin
                busy_r[tail_r]     <= 1'b1;
                ready_r[tail_r]    <= 1'b0;
                has_dest_r[tail_r] <= dispatch_has_dest;
                dest_reg_r[tail_r] <= dispatch_dest_reg;
                tail_r             <= tail_r + ROB_ADDR_LEN'(1);
            end
            count_r <= count_r + (ROB_ADDR_LEN+1)'(accept_s)
                               - (ROB_ADDR_LEN+1)'(commit_valid);
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
//   Directed table of per-cycle vectors for the main scenarios, hand-written
//   sequences for flush and has_dest=0 retirement, then randomized traffic
//   checked against a queue-based reference model of the ROB.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        dispatch_valid;
    logic        dispatch_has_dest;
    logic [4:0]  dispatch_dest_reg;
    logic        dispatch_ready;
    logic [2:0]  dispatch_rob_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_rob_tag;
    logic [31:0] cdb_value;
    logic [2:0]  query_tag1;
    logic [2:0]  query_tag2;
    logic        query_ready1;
    logic        query_ready2;
    logic [31:0] query_value1;
    logic [31:0] query_value2;
    logic        commit_valid;
    logic        commit_has_dest;
    logic [4:0]  commit_reg_addr;
    logic [2:0]  commit_rob_tag;
    logic [31:0] commit_value;
    logic        empty;

    int n_checks;
    int n_fail;

    reorder_buffer dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .dispatch_valid    (dispatch_valid),
        .dispatch_has_dest (dispatch_has_dest),
        .dispatch_dest_reg (dispatch_dest_reg),
        .dispatch_ready    (dispatch_ready),
        .dispatch_rob_tag  (dispatch_rob_tag),
        .cdb_valid         (cdb_valid),
        .cdb_rob_tag       (cdb_rob_tag),
        .cdb_value         (cdb_value),
        .query_tag1        (query_tag1),
        .query_tag2        (query_tag2),
        .query_ready1      (query_ready1),
        .query_ready2      (query_ready2),
        .query_value1      (query_value1),
        .query_value2      (query_value2),
        .commit_valid      (commit_valid),
        .commit_has_dest   (commit_has_dest),
        .commit_reg_addr   (commit_reg_addr),
        .commit_rob_tag    (commit_rob_tag),
        .commit_value      (commit_value),
        .empty             (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        dv;
        logic        hd;
        logic [4:0]  dr;
        logic        cv;
        logic [2:0]  ct;
        logic [31:0] cval;
        logic [2:0]  q1;
        logic        e_drdy;
        logic [2:0]  e_dtag;
        logic        e_cv;
        logic [2:0]  e_ctag;
        logic        e_chd;
        logic [4:0]  e_creg;
        logic [31:0] e_cval;
        logic        e_empty;
        logic        e_qr1;
        logic [31:0] e_qv1;
    } vec_t;

    vec_t tbl[$];

    // Reference model: program-order queue of live tags plus per-tag fields.
    int          mq[$];
    bit          m_rdy[8];
    logic [31:0] m_val[8];
    bit          m_hd[8];
    logic [4:0]  m_dr[8];
    int          m_tail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs on the falling edge; outputs settle 1 time unit later.
    task automatic drive(input logic fl, input logic dv, input logic hd, input logic [4:0] dr,
                         input logic cv, input logic [2:0] ct, input logic [31:0] cval,
                         input logic [2:0] q1, input logic [2:0] q2);
        @(negedge clk);
        flush = fl; dispatch_valid = dv; dispatch_has_dest = hd; dispatch_dest_reg = dr;
        cdb_valid = cv; cdb_rob_tag = ct; cdb_value = cval;
        query_tag1 = q1; query_tag2 = q2;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 3'd0, 3'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        flush = 1'b0; dispatch_valid = 1'b0; cdb_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        m_tail = 0;
        for (int i = 0; i < 8; i++) begin
            m_rdy[i] = 1'b0; m_val[i] = 32'd0; m_hd[i] = 1'b0; m_dr[i] = 5'd0;
        end
    endtask

    function automatic bit in_q(input int t);
        foreach (mq[i]) if (mq[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    // One randomized cycle: compare against the model, then advance the model.
    task automatic rand_cycle();
        logic        fl, dv, hd, cv;
        logic [4:0]  dr;
        logic [2:0]  ct, q1, q2;
        logic [31:0] cval;
        bit          e_cv, e_dr, f1, f2;
        int          h;
        fl   = ($urandom_range(0, 99) < 3);
        dv   = ($urandom_range(0, 99) < 60);
        hd   = ($urandom_range(0, 99) < 75);
        dr   = 5'($urandom_range(0, 31));
        cv   = ($urandom_range(0, 99) < 55);
        if (mq.size() > 0 && $urandom_range(0, 99) < 80)
            ct = 3'(mq[$urandom_range(0, mq.size() - 1)]);
        else
            ct = 3'($urandom_range(0, 7));
        cval = $urandom;
        q1   = 3'($urandom_range(0, 7));
        q2   = 3'($urandom_range(0, 7));
        drive(fl, dv, hd, dr, cv, ct, cval, q1, q2);

        e_dr = (mq.size() < 8);
        e_cv = (mq.size() > 0) && m_rdy[mq[0]] && !fl;
        chk("rnd_dispatch_ready", {31'd0, dispatch_ready}, {31'd0, e_dr});
        chk("rnd_dispatch_tag", {29'd0, dispatch_rob_tag}, 32'(m_tail));
        chk("rnd_empty", {31'd0, empty}, {31'd0, mq.size() == 0});
        chk("rnd_commit_valid", {31'd0, commit_valid}, {31'd0, e_cv});
        if (e_cv) begin
            h = mq[0];
            chk("rnd_commit_tag", {29'd0, commit_rob_tag}, 32'(h));
            chk("rnd_commit_has_dest", {31'd0, commit_has_dest}, {31'd0, m_hd[h]});
            chk("rnd_commit_reg", {27'd0, commit_reg_addr}, {27'd0, m_dr[h]});
            chk("rnd_commit_value", commit_value, m_val[h]);
        end
        f1 = cv && (ct == q1) && in_q(int'(q1));
        f2 = cv && (ct == q2) && in_q(int'(q2));
        chk("rnd_query_ready1", {31'd0, query_ready1}, {31'd0, f1 || (in_q(int'(q1)) && m_rdy[q1])});
        chk("rnd_query_ready2", {31'd0, query_ready2}, {31'd0, f2 || (in_q(int'(q2)) && m_rdy[q2])});
        if (f1 || (in_q(int'(q1)) && m_rdy[q1]))
            chk("rnd_query_value1", query_value1, f1 ? cval : m_val[q1]);
        if (f2 || (in_q(int'(q2)) && m_rdy[q2]))
            chk("rnd_query_value2", query_value2, f2 ? cval : m_val[q2]);

        // Model update for the coming edge.
        if (fl) begin
            mq.delete();
            m_tail = 0;
            for (int i = 0; i < 8; i++) m_rdy[i] = 1'b0;
        end else begin
            if (cv && in_q(int'(ct))) begin
                m_rdy[ct] = 1'b1;
                m_val[ct] = cval;
            end
            if (e_cv) begin
                m_rdy[mq[0]] = 1'b0;
                void'(mq.pop_front());
            end
            if (dv && e_dr) begin
                mq.push_back(m_tail);
                m_rdy[m_tail] = 1'b0;
                m_hd[m_tail]  = hd;
                m_dr[m_tail]  = dr;
                m_tail = (m_tail + 1) % 8;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; dispatch_has_dest = 1'b0;
        dispatch_dest_reg = 5'd0; cdb_valid = 1'b0; cdb_rob_tag = 3'd0; cdb_value = 32'd0;
        query_tag1 = 3'd0; query_tag2 = 3'd0;

        // Reset state.
        do_reset();
        idle();
        chk("rst_dispatch_ready", {31'd0, dispatch_ready}, 32'd1);
        chk("rst_dispatch_tag", {29'd0, dispatch_rob_tag}, 32'd0);
        chk("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
        chk("rst_commit_has_dest", {31'd0, commit_has_dest}, 32'd0);
        chk("rst_commit_reg", {27'd0, commit_reg_addr}, 32'd0);
        chk("rst_commit_tag", {29'd0, commit_rob_tag}, 32'd0);
        chk("rst_commit_value", commit_value, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_query_ready1", {31'd0, query_ready1}, 32'd0);
        chk("rst_query_ready2", {31'd0, query_ready2}, 32'd0);

        // Directed table: fill, overflow attempt, out-of-order completion,
        // full-with-commit, wrap, same-cycle query forwarding.
        for (int i = 0; i < 8; i++)
            tbl.push_back('{1'b0, 1'b1, 1'b1, 5'(i + 1), 1'b0, 3'd0, 32'd0, 3'd0,
                            1'b1, 3'(i), 1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 1'(i == 0), 1'b0, 32'd0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 5'd9,  1'b0, 3'd0, 32'd0,      3'd0,
                        1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 32'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 3'd2, 32'h22,     3'd2,
                        1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b1, 32'h22});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 3'd0, 32'h11,     3'd2,
                        1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b1, 32'h22});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 5'd10, 1'b0, 3'd0, 32'd0,      3'd0,
                        1'b0, 3'd0, 1'b1, 3'd0, 1'b1, 5'd1, 32'h11, 1'b0, 1'b1, 32'h11});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 5'd10, 1'b0, 3'd0, 32'd0,      3'd1,
                        1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 32'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 3'd0, 32'd0,      3'd3,
                        1'b0, 3'd1, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 32'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 3'd3, 32'hABCD,   3'd3,
                        1'b0, 3'd1, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b1, 32'hABCD});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 3'd0, 32'd0,      3'd3,
                        1'b0, 3'd1, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b1, 32'hABCD});

        foreach (tbl[i]) begin
            drive(tbl[i].fl, tbl[i].dv, tbl[i].hd, tbl[i].dr, tbl[i].cv, tbl[i].ct,
                  tbl[i].cval, tbl[i].q1, 3'd0);
            chk($sformatf("tbl%0d_dispatch_ready", i), {31'd0, dispatch_ready}, {31'd0, tbl[i].e_drdy});
            chk($sformatf("tbl%0d_dispatch_tag", i), {29'd0, dispatch_rob_tag}, {29'd0, tbl[i].e_dtag});
            chk($sformatf("tbl%0d_commit_valid", i), {31'd0, commit_valid}, {31'd0, tbl[i].e_cv});
            chk($sformatf("tbl%0d_empty", i), {31'd0, empty}, {31'd0, tbl[i].e_empty});
            chk($sformatf("tbl%0d_query_ready1", i), {31'd0, query_ready1}, {31'd0, tbl[i].e_qr1});
            if (tbl[i].e_cv) begin
                chk($sformatf("tbl%0d_commit_tag", i), {29'd0, commit_rob_tag}, {29'd0, tbl[i].e_ctag});
                chk($sformatf("tbl%0d_commit_has_dest", i), {31'd0, commit_has_dest}, {31'd0, tbl[i].e_chd});
                chk($sformatf("tbl%0d_commit_reg", i), {27'd0, commit_reg_addr}, {27'd0, tbl[i].e_creg});
                chk($sformatf("tbl%0d_commit_value", i), commit_value, tbl[i].e_cval);
            end
            if (tbl[i].e_qr1)
                chk($sformatf("tbl%0d_query_value1", i), query_value1, tbl[i].e_qv1);
        end

        // Flush from a full ROB with a simultaneous dispatch and CDB.
        drive(1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 3'd1, 32'h55, 3'd0, 3'd0);
        chk("flush1_commit_valid", {31'd0, commit_valid}, 32'd0);
        idle();
        chk("flush1_empty", {31'd0, empty}, 32'd1);
        chk("flush1_dispatch_tag", {29'd0, dispatch_rob_tag}, 32'd0);
        chk("flush1_dispatch_ready", {31'd0, dispatch_ready}, 32'd1);

        // Store-like entry (has_dest=0) retires; head then moves to the next entry.
        drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 3'd0, 3'd0);
        chk("st_dispatch_tag0", {29'd0, dispatch_rob_tag}, 32'd0);
        drive(1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 3'd0, 32'd0, 3'd0, 3'd0);
        chk("st_dispatch_tag1", {29'd0, dispatch_rob_tag}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 3'd0, 32'd5, 3'd0, 3'd0);
        chk("st_no_bypass_commit", {31'd0, commit_valid}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 3'd1, 32'd6, 3'd0, 3'd0);
        chk("st_commit_valid", {31'd0, commit_valid}, 32'd1);
        chk("st_commit_has_dest", {31'd0, commit_has_dest}, 32'd0);
        chk("st_commit_tag", {29'd0, commit_rob_tag}, 32'd0);
        idle();
        chk("st_next_commit_valid", {31'd0, commit_valid}, 32'd1);
        chk("st_next_commit_tag", {29'd0, commit_rob_tag}, 32'd1);
        chk("st_next_commit_has_dest", {31'd0, commit_has_dest}, 32'd1);
        chk("st_next_commit_reg", {27'd0, commit_reg_addr}, 32'd7);
        chk("st_next_commit_value", commit_value, 32'd6);
        idle();
        chk("st_drained_empty", {31'd0, empty}, 32'd1);

        // Flush with 5 busy entries and a ready head: commit must be suppressed.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1, 5'(11 + i), 1'b0, 3'd0, 32'd0, 3'd0, 3'd0);
            chk($sformatf("fl5_dispatch_tag%0d", i), {29'd0, dispatch_rob_tag}, 32'(2 + i));
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 3'd2, 32'h77, 3'd0, 3'd0);
        drive(1'b1, 1'b1, 1'b1, 5'd20, 1'b1, 3'd3, 32'h99, 3'd3, 3'd0);
        chk("fl5_commit_suppressed", {31'd0, commit_valid}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 3'd3, 3'd0);
        chk("fl5_empty", {31'd0, empty}, 32'd1);
        chk("fl5_dispatch_tag", {29'd0, dispatch_rob_tag}, 32'd0);
        chk("fl5_dispatch_ready", {31'd0, dispatch_ready}, 32'd1);
        chk("fl5_commit_valid", {31'd0, commit_valid}, 32'd0);
        chk("fl5_query_ready1", {31'd0, query_ready1}, 32'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) rand_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular, in-order reorder buffer for the Tomasulo core. It sits directly beside the register map table and owns the ROB tags that the map table records.
- Dispatch allocates the tail entry and returns its tag. The CDB marks entries complete. The head entry retires in order and drives the map table's return interface and the architectural register file write.
- Operand lookup ports let rename/dispatch fetch values of completed-but-uncommitted producers.

Parameters:
- ROB_SIZE, 8, number of entries; must be a power of two.
- ROB_ADDR_LEN, 3, tag width, equal to log2(ROB_SIZE).
- REG_ADDR_LEN, 5, architectural register index width.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  mispredict/exception squash of all entries.
- dispatch_valid  in  1  allocate request.
- dispatch_has_dest  in  1  instruction writes a register.
- dispatch_dest_reg  in  REG_ADDR_LEN  destination architectural register.
- dispatch_ready  out  1  ROB can accept an allocation this cycle.
- dispatch_rob_tag  out  ROB_ADDR_LEN  tag that is or will be assigned (current tail).
- cdb_valid  in  1  completion broadcast.
- cdb_rob_tag  in  ROB_ADDR_LEN  completing entry.
- cdb_value  in  XLEN  result value.
- query_tag1, query_tag2  in  ROB_ADDR_LEN  source operand tags from the map table.
- query_ready1, query_ready2  out  1  the queried entry's value is available.
- query_value1, query_value2  out  XLEN  the queried entry's value.
- commit_valid  out  1  head retires this cycle (return_flag to map table).
- commit_has_dest  out  1  retiring entry writes the register file.
- commit_reg_addr  out  REG_ADDR_LEN  register address for the retiring entry (to map table and regfile).
- commit_rob_tag  out  ROB_ADDR_LEN  tag of the retiring entry.
- commit_value  out  XLEN  value of the retiring entry.
- empty  out  1  no busy entries.

Behaviour:
- State:
  - Per entry: busy, ready, has_dest, dest_reg, value.
  - head and tail pointers, ROB_ADDR_LEN bits each, wrapping modulo ROB_SIZE.
  - count, ROB_ADDR_LEN+1 bits, range 0..ROB_SIZE.
- Reset and flush:
  - All busy/ready cleared; head=tail=count=0.
  - Reset also zeroes values. Flush does not need to.
  - Output values after reset: dispatch_ready=1, dispatch_rob_tag=0, commit_valid=0, commit_* = 0, empty=1, query_ready*=0.
- Flush priority: flush overrides dispatch, CDB and commit in the same cycle. commit_valid is forced to 0 while flush=1.
- Dispatch:
  - dispatch_ready = (count < ROB_SIZE). This is combinational from registered count only.
  - A dispatch is accepted when dispatch_valid && dispatch_ready.
  - On acceptance, at the clock edge: entry[tail] gets busy=1, ready=0, has_dest, dest_reg; tail advances by 1.
  - dispatch_rob_tag = tail, combinational.
  - dispatch_valid while not ready is ignored; no state change.
- Completion:
  - On cdb_valid with busy[cdb_rob_tag]=1: set ready=1 and value=cdb_value at the edge.
  - A CDB write to a non-busy entry is ignored.
  - A repeat CDB write to an already-ready entry overwrites the value. This is legal but not expected.
- Commit:
  - commit_valid = busy[head] && ready[head] && !flush. This is combinational from registered state.
  - commit_* fields are driven from entry[head].
  - On commit, at the edge: busy[head]=0, ready[head]=0, head advances by 1.
  - Entries with has_dest=0 still retire, with commit_has_dest=0.
- Latency:
  - Dispatch in cycle N makes the entry visible from N+1.
  - A CDB write in cycle N to the head entry yields commit_valid in N+1. There is no same-cycle CDB-to-commit bypass.
  - Maximum throughput is one dispatch and one commit per cycle.
- Count update:
  - count' = count + accept - commit.
  - Simultaneous dispatch and commit leaves count unchanged.
  - When full (count=ROB_SIZE), dispatch_ready=0 even if the head commits in that cycle. There is no full-bypass.
- Query:
  - query_readyK = busy[tag] && ready[tag], with CDB forwarding.
  - Forwarding: if cdb_valid && cdb_rob_tag==query_tagK && busy[query_tagK], then ready=1 and value=cdb_value.
  - Otherwise query_valueK = value[tag]. It is 0-qualified only by ready.
- empty = (count==0).
- Wrap-around: head and tail wrap from ROB_SIZE-1 to 0 with no bubble.
- Full vs empty is distinguished by count, never by pointer equality.

Test Plan:
1. Reset, then 8 dispatches (dest r1..r8) -> tags 0..7 returned; dispatch_ready=0 after the 8th; a 9th dispatch_valid is ignored; count=8.
2. Out-of-order completion: CDB tag2=0x22, then tag0=0x11 -> no commit until tag0. The cycle after the tag0 CDB, commit_valid=1 with tag0/r1/0x11. Next cycle, no commit (tag1 not ready).
3. Full ROB with the head ready and dispatch_valid=1 in the same cycle -> dispatch rejected and head commits. Next cycle, dispatch_ready=1 and a dispatch returns tag0 (wrap).
4. Query forwarding: entry 3 busy and not ready; query_tag1=3 with a simultaneous CDB tag3=0xABCD -> query_ready1=1, query_value1=0xABCD in the same cycle.
5. Flush with 5 busy entries plus a simultaneous dispatch and CDB -> commit_valid=0 that cycle; next cycle empty=1, dispatch_rob_tag=0, count=0.
6. Store-like entry (has_dest=0) completes -> commit_valid=1, commit_has_dest=0; head advances normally.
